// File: rtl/reg_read_unit.sv
// ID-stage register read: owns the general register file and resolves
// operands by forwarding from EX, MEM and WB, with load-use stall detection.
module reg_read_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en_1,
    input  logic                  read_en_2,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    input  logic                  ex_write_en,
    input  logic [ADDR_WIDTH-1:0] ex_write_addr,
    input  logic [DATA_WIDTH-1:0] ex_write_data,
    input  logic                  ex_load_flag,
    input  logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] mem_write_addr,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  wb_write_en,
    input  logic [ADDR_WIDTH-1:0] wb_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  load_related_stall,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    typedef struct packed {
        logic                  hazard;
        logic [DATA_WIDTH-1:0] data;
    } operand_t;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    operand_t op_1;
    operand_t op_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write_en && wb_write_addr != '0) begin
            regs[wb_write_addr] <= wb_write_data;
        end
    end

    // Youngest producer wins; an EX load has no data yet, so it zeroes
    // the operand and flags a hazard regardless of older matches.
    function automatic operand_t resolve(
        input logic                  en,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] rf_data
    );
        operand_t r;
        r.hazard = 1'b0;
        r.data   = '0;
        if (rst || !en || addr == '0) begin
            r.data = '0;
        end else if (ex_write_en && ex_write_addr == addr) begin
            if (ex_load_flag) begin
                r.hazard = 1'b1;
            end else begin
                r.data = ex_write_data;
            end
        end else if (mem_write_en && mem_write_addr == addr) begin
            r.data = mem_write_data;
        end else if (wb_write_en && wb_write_addr == addr) begin
            r.data = wb_write_data;
        end else begin
            r.data = rf_data;
        end
        return r;
    endfunction

    always_comb begin
        op_1 = resolve(read_en_1, read_addr_1, regs[read_addr_1]);
        op_2 = resolve(read_en_2, read_addr_2, regs[read_addr_2]);
    end

    assign read_data_1        = op_1.data;
    assign read_data_2        = op_2.data;
    assign load_related_stall = op_1.hazard | op_2.hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (load_related_stall && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
